// File: rtl/trigger_tx_startup_ctrl.sv
// ---------------------------------------------------------------------------
// trigger_tx_startup_ctrl
//
// Sequences startup and recovery of the trigger GTX transmitters (CSC R/L,
// GEM R/L) on clk_40. It drives the shared TX PLL reset, the GTX TX reset and
// the link-logic reset. It then waits for all PLL locks and reset-dones,
// retries on timeout, and re-sequences when lock is lost.
//
// Optional feature: define TRIG_TX_LOCK_DEBOUNCE_EN to require LOCK_STABLE
// consecutive cycles of full lock before leaving WAIT_LOCK.
//
// Ports:
//   clk_40          in   40 MHz system clock (only clock)
//   reset_n         in   asynchronous active-low reset
//   start_i         in   1-cycle soft restart request
//   pll_locked_i    in   [NLINKS] TX PLL lock, asynchronous
//   tx_resetdone_i  in   [NLINKS] GTX TXRESETDONE, asynchronous
//   txpll_rst_o     out  TX PLL reset to all links
//   gtx_tx_rst_o    out  GTX TX reset to all links
//   link_rst_o      out  link-logic reset to all links
//   ready_o         out  links up
//   fail_o          out  retry budget exhausted
//   state_o         out  [3] current state
//   retry_cnt_o     out  [2] consecutive failed attempts
//   lock_loss_cnt_o out  [8] cumulative lock losses, saturating
// ---------------------------------------------------------------------------
module trigger_tx_startup_ctrl #(
  parameter int NLINKS       = 4,
  parameter int PLL_RST_CYC  = 16,
  parameter int TX_RST_CYC   = 16,
  parameter int LINK_RST_CYC = 16,
  parameter int TIMEOUT_CYC  = 4096,
  parameter int MAX_RETRIES  = 3,
  parameter int LOCK_STABLE  = 64
) (
  input  logic              clk_40,
  input  logic              reset_n,
  input  logic              start_i,
  input  logic [NLINKS-1:0] pll_locked_i,
  input  logic [NLINKS-1:0] tx_resetdone_i,
  output logic              txpll_rst_o,
  output logic              gtx_tx_rst_o,
  output logic              link_rst_o,
  output logic              ready_o,
  output logic              fail_o,
  output logic [2:0]        state_o,
  output logic [1:0]        retry_cnt_o,
  output logic [7:0]        lock_loss_cnt_o
);

  // Wide enough for the longest phase or timeout.
  localparam int CW = $clog2(TIMEOUT_CYC + PLL_RST_CYC + TX_RST_CYC + LINK_RST_CYC + 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PLL_RST   = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_TX_RST    = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_LINK_RST  = 3'd5,
    ST_READY     = 3'd6,
    ST_FAIL      = 3'd7
  } state_t;

  state_t            state_r, state_nx_s;
  logic [CW-1:0]     cnt_r, cnt_nx_s;
  logic [1:0]        retry_r, retry_nx_s;
  logic [7:0]        loss_r, loss_nx_s;
  logic [4:0]        outs_r;
  logic [NLINKS-1:0] lock_meta_r, lock_sync_r, done_meta_r, done_sync_r;
  logic              all_locked_s, all_done_s, lock_ok_s, loss_s, retry_req_s;

  // Output levels {txpll, gtx, link, ready, fail} for a given state.
  function automatic logic [4:0] decode_outs(input state_t st);
    case (st)
      ST_IDLE:      decode_outs = 5'b11100;
      ST_PLL_RST:   decode_outs = 5'b11100;
      ST_WAIT_LOCK: decode_outs = 5'b01100;
      ST_TX_RST:    decode_outs = 5'b01100;
      ST_WAIT_DONE: decode_outs = 5'b00100;
      ST_LINK_RST:  decode_outs = 5'b00100;
      ST_READY:     decode_outs = 5'b00010;
      ST_FAIL:      decode_outs = 5'b01101;
      default:      decode_outs = 5'b11100;
    endcase
  endfunction

  // Two-flop synchronizers for the asynchronous status inputs.
  always_ff @(posedge clk_40 or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta_r <= '0;
      lock_sync_r <= '0;
      done_meta_r <= '0;
      done_sync_r <= '0;
    end else begin
      lock_meta_r <= pll_locked_i;
      lock_sync_r <= lock_meta_r;
      done_meta_r <= tx_resetdone_i;
      done_sync_r <= done_meta_r;
    end
  end

  assign all_locked_s = &lock_sync_r;
  assign all_done_s   = &done_sync_r;

`ifdef TRIG_TX_LOCK_DEBOUNCE_EN
  localparam int SW = $clog2(LOCK_STABLE + 1);
  logic [SW-1:0] stable_r, stable_nx_s;

  // Consecutive full-lock cycles while in WAIT_LOCK; a drop restarts it
  // without touching the timeout counter.
  always_comb begin
    stable_nx_s = '0;
    if (state_r == ST_WAIT_LOCK && all_locked_s) begin
      stable_nx_s = stable_r + SW'(1);
    end else begin
      stable_nx_s = '0;
    end
  end

  // Stable-lock counter register.
  always_ff @(posedge clk_40 or negedge reset_n) begin
    if (!reset_n) begin
      stable_r <= '0;
    end else begin
      stable_r <= stable_nx_s;
    end
  end

  assign lock_ok_s = all_locked_s && (stable_r == SW'(LOCK_STABLE - 1));
`else
  assign lock_ok_s = all_locked_s;
`endif

  // Next-state, retry and lock-loss bookkeeping.
  always_comb begin
    state_nx_s  = state_r;
    retry_nx_s  = retry_r;
    loss_nx_s   = loss_r;
    cnt_nx_s    = cnt_r;
    loss_s      = 1'b0;
    retry_req_s = 1'b0;

    case (state_r)
      ST_IDLE: state_nx_s = ST_PLL_RST;
      ST_PLL_RST: begin
        if (cnt_r == CW'(PLL_RST_CYC - 1)) state_nx_s = ST_WAIT_LOCK;
        else                               state_nx_s = ST_PLL_RST;
      end
      ST_WAIT_LOCK: begin
        if (lock_ok_s)                          state_nx_s = ST_TX_RST;
        else if (cnt_r == CW'(TIMEOUT_CYC - 1)) retry_req_s = 1'b1;
        else                                    state_nx_s = ST_WAIT_LOCK;
      end
      ST_TX_RST: begin
        if (!all_locked_s)                     loss_s = 1'b1;
        else if (cnt_r == CW'(TX_RST_CYC - 1)) state_nx_s = ST_WAIT_DONE;
        else                                   state_nx_s = ST_TX_RST;
      end
      ST_WAIT_DONE: begin
        if (!all_locked_s)                      loss_s = 1'b1;
        else if (all_done_s)                    state_nx_s = ST_LINK_RST;
        else if (cnt_r == CW'(TIMEOUT_CYC - 1)) retry_req_s = 1'b1;
        else                                    state_nx_s = ST_WAIT_DONE;
      end
      ST_LINK_RST: begin
        if (!all_locked_s) begin
          loss_s = 1'b1;
        end else if (cnt_r == CW'(LINK_RST_CYC - 1)) begin
          state_nx_s = ST_READY;
          retry_nx_s = 2'd0;
        end else begin
          state_nx_s = ST_LINK_RST;
        end
      end
      ST_READY: begin
        if (!all_locked_s) loss_s = 1'b1;
        else               state_nx_s = ST_READY;
      end
      ST_FAIL: state_nx_s = ST_FAIL;
      default: state_nx_s = ST_IDLE;
    endcase

    // A restart request overrides any timeout or lock loss seen this cycle.
    if (start_i) begin
      state_nx_s = ST_PLL_RST;
      retry_nx_s = 2'd0;
    end else begin
      if (loss_s) begin
        loss_nx_s   = (loss_r != 8'hFF) ? loss_r + 8'd1 : loss_r;
        retry_req_s = 1'b1;
      end else begin
        loss_nx_s = loss_r;
      end
      if (retry_req_s) begin
        if (retry_r == 2'(MAX_RETRIES - 1)) begin
          state_nx_s = ST_FAIL;
        end else begin
          retry_nx_s = retry_r + 2'd1;
          state_nx_s = ST_PLL_RST;
        end
      end else begin
        retry_nx_s = retry_nx_s;
      end
    end

    // Phase counter restarts on every entry (including restart into
    // PLL_RST from PLL_RST) and saturates instead of wrapping.
    if (start_i || (state_nx_s != state_r)) begin
      cnt_nx_s = '0;
    end else if (cnt_r != {CW{1'b1}}) begin
      cnt_nx_s = cnt_r + CW'(1);
    end else begin
      cnt_nx_s = cnt_r;
    end
  end

  // State, counters and registered outputs; outputs follow the next state
  // so they change in the same cycle as state_o.
  always_ff @(posedge clk_40 or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      retry_r <= 2'd0;
      loss_r  <= 8'd0;
      outs_r  <= 5'b11100;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      retry_r <= retry_nx_s;
      loss_r  <= loss_nx_s;
      outs_r  <= decode_outs(state_nx_s);
    end
  end

  assign txpll_rst_o     = outs_r[4];
  assign gtx_tx_rst_o    = outs_r[3];
  assign link_rst_o      = outs_r[2];
  assign ready_o         = outs_r[1];
  assign fail_o          = outs_r[0];
  assign state_o         = state_r;
  assign retry_cnt_o     = retry_r;
  assign lock_loss_cnt_o = loss_r;

endmodule

// File: tb/tb_trigger_tx_startup_ctrl.sv
`timescale 1ns/1ps
module tb_trigger_tx_startup_ctrl;

  logic       clk_40 = 1'b0;
  logic       reset_n = 1'b0;
  logic       start_i = 1'b0;
  logic [3:0] pll_locked_i = 4'h0;
  logic [3:0] tx_resetdone_i = 4'h0;
  logic       txpll_rst_o, gtx_tx_rst_o, link_rst_o, ready_o, fail_o;
  logic [2:0] state_o;
  logic [1:0] retry_cnt_o;
  logic [7:0] lock_loss_cnt_o;

  int checks = 0;
  int failures = 0;

`ifdef TRIG_TX_LOCK_DEBOUNCE_EN
  localparam int DBD = 7;
`else
  localparam int DBD = 0;
`endif

  trigger_tx_startup_ctrl #(
    .NLINKS(4), .PLL_RST_CYC(4), .TX_RST_CYC(4), .LINK_RST_CYC(4),
    .TIMEOUT_CYC(32), .MAX_RETRIES(3), .LOCK_STABLE(8)
  ) dut (
    .clk_40(clk_40), .reset_n(reset_n), .start_i(start_i),
    .pll_locked_i(pll_locked_i), .tx_resetdone_i(tx_resetdone_i),
    .txpll_rst_o(txpll_rst_o), .gtx_tx_rst_o(gtx_tx_rst_o), .link_rst_o(link_rst_o),
    .ready_o(ready_o), .fail_o(fail_o), .state_o(state_o),
    .retry_cnt_o(retry_cnt_o), .lock_loss_cnt_o(lock_loss_cnt_o)
  );

  always #5 clk_40 = ~clk_40;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int         ncyc;
    logic [3:0] lock;
    logic [3:0] done;
    logic [2:0] st;
    logic       txpll, gtx, link, ready;
  } vec_t;

  vec_t vecs[14];

  function automatic logic [31:0] pack(input logic [2:0] st, input logic tp, input logic gx,
                                       input logic lk, input logic rd, input logic fl,
                                       input logic [1:0] rc, input logic [7:0] lc);
    return {14'd0, st, tp, gx, lk, rd, fl, rc, lc};
  endfunction

  function automatic logic [31:0] dut_pack();
    return pack(state_o, txpll_rst_o, gtx_tx_rst_o, link_rst_o, ready_o, fail_o,
                retry_cnt_o, lock_loss_cnt_o);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_40);
      #1;
    end
  endtask

  task automatic wait_state(input logic [2:0] st, input string name);
    int k = 0;
    while (state_o !== st && k < 200) begin
      tick(1);
      k++;
    end
    check(name, {29'd0, state_o}, {29'd0, st});
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
  endtask

  initial begin
    logic stayed;
    // Startup sequence: lock after edge 20, resetdone 10 cycles after gtx reset falls.
    vecs[0]  = '{1,        4'h0, 4'h0, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{3,        4'h0, 4'h0, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1,        4'h0, 4'h0, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{15,       4'h0, 4'h0, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{2 + DBD,  4'hF, 4'h0, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1,        4'hF, 4'h0, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{3,        4'hF, 4'h0, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1,        4'hF, 4'h0, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{10,       4'hF, 4'h0, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{2,        4'hF, 4'hF, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1,        4'hF, 4'hF, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{3,        4'hF, 4'hF, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1,        4'hF, 4'hF, 3'd6, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{5,        4'hF, 4'hF, 3'd6, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset state.
    tick(2);
    check("reset_state", dut_pack(), pack(3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0));
    reset_n = 1'b1;

    // 1. Nominal startup.
    for (int i = 0; i < 14; i++) begin
      pll_locked_i   = vecs[i].lock;
      tx_resetdone_i = vecs[i].done;
      tick(vecs[i].ncyc);
      check($sformatf("startup_vec%0d", i), dut_pack(),
            pack(vecs[i].st, vecs[i].txpll, vecs[i].gtx, vecs[i].link, vecs[i].ready,
                 1'b0, 2'd0, 8'd0));
    end

    // Asynchronous reset mid-sequence takes effect without a clock edge.
    reset_n = 1'b0;
    #1;
    check("async_reset", dut_pack(), pack(3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0));

    // 2. No lock: three 32-cycle timeouts then FAIL; start_i recovers.
    pll_locked_i = 4'h0;
    tx_resetdone_i = 4'h0;
    tick(2);
    reset_n = 1'b1;
    tick(37);
    check("retry1", dut_pack(), pack(3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 8'd0));
    tick(36);
    check("retry2", dut_pack(), pack(3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 8'd0));
    tick(35);
    check("last_wait_lock", dut_pack(), pack(3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 8'd0));
    tick(1);
    check("fail_entry", dut_pack(), pack(3'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 8'd0));
    tick(10);
    check("fail_hold", {29'd0, state_o}, 32'd7);
    pll_locked_i = 4'hF;
    tx_resetdone_i = 4'hF;
    pulse_start();
    check("fail_restart", dut_pack(), pack(3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0));

    // 3. One-cycle drop of lock[2] in READY.
    wait_state(3'd6, "reach_ready_t3");
    pll_locked_i = 4'b1011;
    tick(1);
    pll_locked_i = 4'hF;
    tick(1);
    check("loss_latency", {30'd0, state_o == 3'd6, ready_o}, 32'd3);
    tick(1);
    check("loss_restart", dut_pack(), pack(3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 8'd1));
    wait_state(3'd6, "re_ready_t3");
    check("ready_retry_clr", {30'd0, retry_cnt_o}, 32'd0);

    // 4. 300 further lock drops: counter saturates at 255.
    for (int i = 0; i < 300; i++) begin
      wait_state(3'd6, "reach_ready_t4");
      pll_locked_i = 4'b1110;
      tick(1);
      pll_locked_i = 4'hF;
      tick(2);
      if (i == 252) check("loss_cnt_254", {24'd0, lock_loss_cnt_o}, 32'd254);
    end
    check("loss_cnt_sat", {24'd0, lock_loss_cnt_o}, 32'd255);

    // 5a. Plain WAIT_DONE timeout counts a retry.
    tx_resetdone_i = 4'h0;
    pulse_start();
    wait_state(3'd4, "reach_wait_done_a");
    tick(31);
    check("wait_done_hold", {29'd0, state_o}, 32'd4);
    tick(1);
    check("wait_done_timeout", dut_pack(), pack(3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 8'd255));

    // 5b. start_i on the timeout cycle wins; no retry counted.
    wait_state(3'd4, "reach_wait_done_b");
    tick(31);
    check("wait_done_hold_b", {29'd0, state_o}, 32'd4);
    pulse_start();
    check("start_vs_timeout", dut_pack(), pack(3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd255));

    // 6. Glitching lock in WAIT_LOCK.
    pll_locked_i = 4'h0;
    tx_resetdone_i = 4'hF;
    pulse_start();
    wait_state(3'd2, "reach_wait_lock_t6");
`ifdef TRIG_TX_LOCK_DEBOUNCE_EN
    stayed = 1'b1;
    for (int k = 0; k < 31; k++) begin
      pll_locked_i = (k % 5 == 4) ? 4'h0 : 4'hF;
      tick(1);
      if (state_o !== 3'd2) stayed = 1'b0;
    end
    check("debounce_stay", {31'd0, stayed}, 32'd1);
    tick(1);
    check("debounce_timeout", {27'd0, state_o, retry_cnt_o}, {27'd0, 3'd1, 2'd1});
`else
    stayed = 1'b1;
    pll_locked_i = 4'hF;
    tick(2);
    if (state_o !== 3'd2) stayed = 1'b0;
    check("no_debounce_sync", {31'd0, stayed}, 32'd1);
    pll_locked_i = 4'h0;
    tick(1);
    check("no_debounce_exit", {27'd0, state_o, retry_cnt_o}, {27'd0, 3'd3, 2'd0});
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
